// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver data width, RX buffer depth and the byte type.
package uart_pkg;
    localparam int UART_DBIT        = 8;
    localparam int UART_FIFO_ADDR_W = 4;

    typedef logic [UART_DBIT-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host/receiver-facing signals of the UART RX buffer.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DBIT   = UART_DBIT,
    parameter int ADDR_W = UART_FIFO_ADDR_W
);
    logic              wr_tick;
    logic [DBIT-1:0]   wr_data;
    logic              rd;
    logic              ovr_clr;
    logic [DBIT-1:0]   rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;

    modport master (
        output wr_tick, wr_data, rd, ovr_clr,
        input  rd_data, empty, full, count, overrun
    );

    modport slave (
        input  wr_tick, wr_data, rd, ovr_clr,
        output rd_data, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Register array: synchronous write, asynchronous read. Contents are not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DBIT   = UART_DBIT,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DBIT-1:0]   i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DBIT-1:0]   o_rdata
);
    logic [DBIT-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT FIFO with occupancy status and sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = UART_DBIT,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_overrun;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [DBIT-1:0]   w_rdata;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
    assign w_push = bus.wr_tick && (!w_full || bus.rd);
    assign w_pop  = bus.rd && !w_empty;
    assign w_drop = bus.wr_tick && w_full && !bus.rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.rd_data = w_empty ? '0 : w_rdata;
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.count   = r_wr_ptr - r_rd_ptr;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    uart_rx_fifo_if #(.DBIT(UART_DBIT), .ADDR_W(UART_FIFO_ADDR_W)) bus ();

    uart_rx_fifo #(.DBIT(UART_DBIT), .ADDR_W(UART_FIFO_ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_tick = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_tick = 1'b0;
        bus.wr_data = 8'h00;
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        bus.wr_tick   = 1'b0;
        bus.wr_data   = 8'h00;
        bus.rd        = 1'b0;
        bus.ovr_clr   = 1'b0;
        #12;
        reset_n = 1'b1;
        repeat (5) tick();

        // 1: reset state
        chk("rst_empty",   32'(bus.empty),   32'd1);
        chk("rst_full",    32'(bus.full),    32'd0);
        chk("rst_count",   32'(bus.count),   32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);

        // 2: two pushes, FWFT head, two pops
        push(8'hA5);
        chk("t2_lat_empty", 32'(bus.empty),   32'd0);
        chk("t2_lat_data",  32'(bus.rd_data), 32'hA5);
        tick();
        push(8'h3C);
        chk("t2_count2",  32'(bus.count),   32'd2);
        chk("t2_head_a5", 32'(bus.rd_data), 32'hA5);
        pop();
        chk("t2_head_3c", 32'(bus.rd_data), 32'h3C);
        chk("t2_count1",  32'(bus.count),   32'd1);
        pop();
        chk("t2_empty",   32'(bus.empty),   32'd1);
        chk("t2_count0",  32'(bus.count),   32'd0);

        // 3: fill, overrun drop, drain in order
        for (int i = 0; i < 16; i++) begin
            chk("t3_fill_count", 32'(bus.count), 32'(i));
            push(8'(i));
        end
        chk("t3_full",    32'(bus.full),    32'd1);
        chk("t3_count16", 32'(bus.count),   32'd16);
        chk("t3_ovr_pre", 32'(bus.overrun), 32'd0);
        push(8'hFF);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        chk("t3_cnt_ovr", 32'(bus.count),   32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", 32'(bus.rd_data), 32'(i));
            pop();
        end
        chk("t3_empty",     32'(bus.empty),   32'd1);
        chk("t3_no_ff",     32'(bus.rd_data), 32'h00);
        chk("t3_ovr_stick", 32'(bus.overrun), 32'd1);

        // 4: simultaneous push+pop while full
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("t4_ovr_clr", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        chk("t4_full", 32'(bus.full), 32'd1);
        bus.wr_tick = 1'b1;
        bus.wr_data = 8'h77;
        bus.rd      = 1'b1;
        tick();
        bus.wr_tick = 1'b0;
        bus.rd      = 1'b0;
        chk("t4_count16", 32'(bus.count),   32'd16);
        chk("t4_no_ovr",  32'(bus.overrun), 32'd0);
        chk("t4_head",    32'(bus.rd_data), 32'h11);
        for (int i = 0; i < 15; i++) begin
            chk("t4_drain", 32'(bus.rd_data), 32'(8'h11 + i));
            pop();
        end
        chk("t4_last_77", 32'(bus.rd_data), 32'h77);
        chk("t4_count1",  32'(bus.count),   32'd1);
        pop();
        chk("t4_empty", 32'(bus.empty), 32'd1);

        // 5: simultaneous push+rd while empty, rd on empty ignored
        bus.wr_tick = 1'b1;
        bus.wr_data = 8'h5A;
        bus.rd      = 1'b1;
        tick();
        bus.wr_tick = 1'b0;
        bus.rd      = 1'b0;
        chk("t5_count1", 32'(bus.count),   32'd1);
        chk("t5_data",   32'(bus.rd_data), 32'h5A);
        pop();
        pop();
        chk("t5_rd_empty_cnt", 32'(bus.count), 32'd0);
        chk("t5_rd_empty_emp", 32'(bus.empty), 32'd1);
        push(8'h42);
        chk("t5_ptr_count", 32'(bus.count),   32'd1);
        chk("t5_ptr_data",  32'(bus.rd_data), 32'h42);
        pop();

        // 6: set wins over clear, then clear, then async reset mid-operation
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        push(8'hEE);
        chk("t6_ovr_set", 32'(bus.overrun), 32'd1);
        bus.wr_tick = 1'b1;
        bus.wr_data = 8'hEF;
        bus.ovr_clr = 1'b1;
        tick();
        bus.wr_tick = 1'b0;
        chk("t6_set_wins", 32'(bus.overrun), 32'd1);
        chk("t6_cnt16",    32'(bus.count),   32'd16);
        tick();
        bus.ovr_clr = 1'b0;
        chk("t6_clr", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 11; i++) pop();
        chk("t6_count5", 32'(bus.count),   32'd5);
        chk("t6_head",   32'(bus.rd_data), 32'h2B);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_empty", 32'(bus.empty),   32'd1);
        chk("t6_rst_count", 32'(bus.count),   32'd0);
        chk("t6_rst_data",  32'(bus.rd_data), 32'h00);
        chk("t6_rst_full",  32'(bus.full),    32'd0);
        #10;
        reset_n = 1'b1;
        tick();
        chk("t6_post_empty", 32'(bus.empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
